// File: rtl/vga_console_writer.sv
// Terminal-style character engine: turns a byte stream into graphics-memory
// glyph writes, cursor register updates and bus-driven scroll/clear copies.
module vga_console_writer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 60,
  parameter logic [31:0] GM_BASE      = 32'h0000_0000,
  parameter logic [31:0] CUR_EN_ADDR  = 32'h0000_2000,
  parameter logic [31:0] CUR_ROW_ADDR = 32'h0000_2001,
  parameter logic [31:0] CUR_COL_ADDR = 32'h0000_2002
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        char_valid_i,
  input  logic [7:0]  char_i,
  output logic        char_ready_o,
  output logic        bus_cs_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic [7:0]  cursor_row_o,
  output logic [7:0]  cursor_col_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PUT, S_CUR_ROW, S_CUR_COL, S_SCR_RD, S_SCR_WR, S_CLR
  } state_t;

  localparam logic [12:0] COLS13    = 13'(COLS);
  localparam logic [12:0] SCR_LAST  = 13'((ROWS - 1) * COLS - 1);
  localparam logic [12:0] LAST_ROW0 = 13'((ROWS - 1) * COLS);
  localparam logic [12:0] CELL_LAST = 13'(ROWS * COLS - 1);
  localparam logic [7:0]  COL_MAX   = 8'(COLS - 1);
  localparam logic [7:0]  ROW_MAX   = 8'(ROWS - 1);

  state_t      state_q, state_d;
  logic [7:0]  row_q, row_d, col_q, col_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  ch_q, ch_d;
  logic        bs_q, bs_d;
  logic        cs_q, cs_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;

  logic        ack;
  logic        req, req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_byte;
  logic        unused_data_hi;

  assign unused_data_hi = ^bus_data_i[31:8];

  function automatic logic [31:0] gm_addr(input logic [12:0] idx);
    return GM_BASE + {19'd0, idx};
  endfunction

  function automatic logic [12:0] cell_idx(input logic [7:0] r, input logic [7:0] c);
    return 13'(r) * COLS13 + 13'(c);
  endfunction

  // State, cursor, counters and the registered bus request; async reset clears all
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_INIT;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      bs_q    <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      bs_q    <= bs_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state decode: each bus state posts one request, advances on its ack
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    bs_d     = bs_q;
    cs_d     = cs_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    req      = 1'b0;
    req_we   = 1'b1;
    req_addr = '0;
    req_byte = '0;
    ack      = cs_q & bus_ack_i;

    case (state_q)
      S_INIT: begin
        req      = 1'b1;
        req_addr = CUR_EN_ADDR;
        req_byte = 8'd1;
        if (ack) state_d = S_CUR_ROW;
      end
      S_IDLE: begin
        if (char_valid_i) begin
          bs_d = 1'b0;
          if (char_i >= 8'h20 && char_i <= 8'h7E) begin
            ch_d    = char_i;
            state_d = S_PUT;
          end else begin
            case (char_i)
              8'h0A: begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                  cnt_d   = '0;
                  state_d = S_SCR_RD;
                end else begin
                  row_d   = row_q + 8'd1;
                  state_d = S_CUR_ROW;
                end
              end
              8'h0D: begin
                col_d   = '0;
                state_d = S_CUR_ROW;
              end
              8'h08: begin
                if (col_q != 8'd0) begin
                  col_d   = col_q - 8'd1;
                  ch_d    = 8'h20;
                  bs_d    = 1'b1;
                  state_d = S_PUT;
                end else begin
                  state_d = S_CUR_ROW;
                end
              end
              8'h0C: begin
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
                state_d = S_CLR;
              end
              default: ;
            endcase
          end
        end
      end
      S_PUT: begin
        req      = 1'b1;
        req_addr = gm_addr(cell_idx(row_q, col_q));
        req_byte = ch_q;
        if (ack) begin
          // Backspace already moved the cursor at decode; no advance here
          if (bs_q) begin
            state_d = S_CUR_ROW;
          end else if (col_q != COL_MAX) begin
            col_d   = col_q + 8'd1;
            state_d = S_CUR_ROW;
          end else begin
            col_d = '0;
            if (row_q == ROW_MAX) begin
              cnt_d   = '0;
              state_d = S_SCR_RD;
            end else begin
              row_d   = row_q + 8'd1;
              state_d = S_CUR_ROW;
            end
          end
        end
      end
      S_CUR_ROW: begin
        req      = 1'b1;
        req_addr = CUR_ROW_ADDR;
        req_byte = row_q;
        if (ack) state_d = S_CUR_COL;
      end
      S_CUR_COL: begin
        req      = 1'b1;
        req_addr = CUR_COL_ADDR;
        req_byte = col_q;
        if (ack) state_d = S_IDLE;
      end
      S_SCR_RD: begin
        req      = 1'b1;
        req_we   = 1'b0;
        req_addr = gm_addr(cnt_q + COLS13);
        if (ack) begin
          ch_d    = bus_data_i[7:0];
          state_d = S_SCR_WR;
        end
      end
      S_SCR_WR: begin
        req      = 1'b1;
        req_addr = gm_addr(cnt_q);
        req_byte = ch_q;
        if (ack) begin
          // After the last copy, blank only the bottom row
          if (cnt_q == SCR_LAST) begin
            cnt_d   = LAST_ROW0;
            state_d = S_CLR;
          end else begin
            cnt_d   = cnt_q + 13'd1;
            state_d = S_SCR_RD;
          end
        end
      end
      S_CLR: begin
        req      = 1'b1;
        req_addr = gm_addr(cnt_q);
        req_byte = 8'h20;
        if (ack) begin
          if (cnt_q == CELL_LAST) state_d = S_CUR_ROW;
          else                    cnt_d   = cnt_q + 13'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ack closes the transfer; a new one starts only from an idle bus cycle,
    // so the state entered on the ack cycle always sees one cs-low cycle first
    if (ack) begin
      cs_d = 1'b0;
    end else if (req && !cs_q) begin
      cs_d   = 1'b1;
      we_d   = req_we;
      addr_d = req_addr;
      data_d = {24'd0, req_byte};
    end
  end

  assign char_ready_o = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE) & ~reset_i;
  assign bus_cs_o     = cs_q;
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_data_o   = data_q;
  assign cursor_row_o = row_q;
  assign cursor_col_o = col_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Bench for vga_console_writer: bus slave with graphics memory, screen model.
module tb_vga_console_writer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        char_valid_i;
  logic [7:0]  char_i;
  logic        char_ready_o;
  logic        bus_cs_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_data_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;
  logic [7:0]  cursor_row_o, cursor_col_o;
  logic        busy_o;

  always #5 clk = ~clk;

  vga_console_writer dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .char_valid_i (char_valid_i),
    .char_i       (char_i),
    .char_ready_o (char_ready_o),
    .bus_cs_o     (bus_cs_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_data_o   (bus_data_o),
    .bus_data_i   (bus_data_i),
    .bus_ack_i    (bus_ack_i),
    .cursor_row_o (cursor_row_o),
    .cursor_col_o (cursor_col_o),
    .busy_o       (busy_o)
  );

  // ---------------- bus slave: 1-cycle ack, 4800-cell memory ----------------
  logic [7:0]  mem [0:4799];
  logic [7:0]  reg_en = '0, reg_row = '0, reg_col = '0;
  logic [40:0] log_q [$];
  logic [31:0] rnd_q = '0;
  logic        ack_d1 = 1'b0;
  int          proto_err = 0, hi_err = 0;
  bit          fill_req = 1'b0;
  logic [7:0]  fill_val = '0;
  int          fill_lo = 0, fill_hi = 0;

  always @(posedge clk) begin
    rnd_q  <= $urandom;
    ack_d1 <= bus_ack_i;
    if (fill_req)
      for (int i = fill_lo; i <= fill_hi; i++) mem[i] <= fill_val;
    if (!reset_i && ack_d1 && bus_cs_o) proto_err <= proto_err + 1;
    if (bus_cs_o && !bus_ack_i) begin
      bus_ack_i  <= 1'b1;
      bus_data_i <= rnd_q;
      log_q.push_back({bus_we_o, bus_addr_o, bus_data_o[7:0]});
      if (bus_we_o && bus_data_o[31:8] != 24'd0) hi_err <= hi_err + 1;
      if (bus_addr_o < 32'd4800) begin
        if (bus_we_o) mem[bus_addr_o[12:0]] <= bus_data_o[7:0];
        else          bus_data_i <= {rnd_q[31:8], mem[bus_addr_o[12:0]]};
      end else if (bus_we_o) begin
        if (bus_addr_o == 32'h2000) reg_en  <= bus_data_o[7:0];
        if (bus_addr_o == 32'h2001) reg_row <= bus_data_o[7:0];
        if (bus_addr_o == 32'h2002) reg_col <= bus_data_o[7:0];
      end
    end else begin
      bus_ack_i <= 1'b0;
    end
  end

  // ---------------- screen model ----------------
  logic [7:0] scr [0:4799];
  logic [7:0] pre [0:4799];
  int mrow, mcol;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] ent(input bit we, input logic [31:0] a, input logic [7:0] d);
    return {we, a, d};
  endfunction

  task automatic model_newline();
    if (mrow < 59) mrow++;
    else begin
      for (int i = 0; i < 4720; i++) scr[i] = scr[i + 80];
      for (int i = 4720; i < 4800; i++) scr[i] = 8'h20;
    end
  endtask

  task automatic model_apply(input logic [7:0] b, output bit active);
    active = 1'b1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow * 80 + mcol] = b;
      if (mcol < 79) mcol++;
      else begin mcol = 0; model_newline(); end
    end else if (b == 8'h0A) begin
      mcol = 0; model_newline();
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin mcol--; scr[mrow * 80 + mcol] = 8'h20; end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < 4800; i++) scr[i] = 8'h20;
      mrow = 0; mcol = 0;
    end else begin
      active = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!char_ready_o && n < 200) begin @(negedge clk); n++; end
    check("ready_wait", char_ready_o, 1);
    char_i = b; char_valid_i = 1'b1;
    @(posedge clk); #1;
    char_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (!busy_o) begin ok = 1'b1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_byte(input logic [7:0] b, input int bound, output bit active);
    bit ok;
    log_q.delete();
    send_byte(b);
    wait_idle(bound, ok);
    check("byte_done", ok, 1);
    model_apply(b, active);
  endtask

  task automatic check_byte(input bit active);
    int n;
    n = log_q.size();
    check("cur_row_o", cursor_row_o, mrow);
    check("cur_col_o", cursor_col_o, mcol);
    if (active) begin
      check("pub_row", (n >= 2) ? log_q[n-2] : '0, ent(1, 32'h2001, 8'(mrow)));
      check("pub_col", (n >= 2) ? log_q[n-1] : '0, ent(1, 32'h2002, 8'(mcol)));
    end else begin
      check("discard_nobus", n, 0);
    end
  endtask

  task automatic check_init(input string tag);
    check({tag, "_n"},   log_q.size(), 3);
    check({tag, "_en"},  log_q.size() > 0 ? log_q[0] : '0, ent(1, 32'h2000, 8'd1));
    check({tag, "_row"}, log_q.size() > 1 ? log_q[1] : '0, ent(1, 32'h2001, 8'd0));
    check({tag, "_col"}, log_q.size() > 2 ? log_q[2] : '0, ent(1, 32'h2002, 8'd0));
    check({tag, "_rdy"}, char_ready_o, 1);
    check({tag, "_cur"}, {cursor_row_o, cursor_col_o}, 16'h0000);
  endtask

  task automatic mem_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < 4800; i++) if (mem[i] !== scr[i]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    bit ok, act;
    logic [7:0] b;
    int n, bad, rd;

    reset_i = 1'b1; char_valid_i = 1'b0; char_i = '0;
    fill_lo = 0; fill_hi = 4799; fill_val = 8'h00; fill_req = 1'b1;
    for (int i = 0; i < 4800; i++) scr[i] = 8'h00;
    mrow = 0; mcol = 0;
    @(posedge clk); #1 fill_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs",   bus_cs_o, 0);
    check("rst_we",   bus_we_o, 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_data", bus_data_o, 0);
    check("rst_row",  cursor_row_o, 0);
    check("rst_col",  cursor_col_o, 0);
    check("rst_rdy",  char_ready_o, 0);
    check("rst_busy", busy_o, 0);

    log_q.delete();
    @(negedge clk) reset_i = 1'b0;
    @(posedge clk); #1;
    wait_idle(100, ok);
    check("init_done", ok, 1);
    check_init("init");

    // 'A' at 0,0
    do_byte(8'h41, 100, act);
    check("A_n",   log_q.size(), 3);
    check("A_gm",  log_q.size() > 0 ? log_q[0] : '0, ent(1, 32'h0, 8'h41));
    check_byte(act);
    check("A_col", cursor_col_o, 1);

    // fill to column 79, then 'Z' wraps to next row
    for (int i = 0; i < 78; i++) begin
      do_byte(8'($urandom_range(8'h20, 8'h7E)), 100, act);
      check_byte(act);
    end
    do_byte(8'h5A, 100, act);
    check("Z_gm",  log_q.size() > 0 ? log_q[0] : '0, ent(1, 32'd79, 8'h5A));
    check("Z_n",   log_q.size(), 3);
    check("Z_cur", {cursor_row_o, cursor_col_o}, 16'h0100);
    check_byte(act);

    // random mix of printables and control codes, kept away from the bottom row
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 15);
      case (n)
        0: b = 8'h0A;
        1: b = 8'h0D;
        2, 3: b = 8'h08;
        4: b = ($urandom_range(0, 1) != 0) ? 8'h07 : 8'(8'h80 + $urandom_range(0, 127));
        default: b = 8'($urandom_range(8'h20, 8'h7E));
      endcase
      if (mrow == 59 && (b == 8'h0A || (mcol == 79 && b >= 8'h20 && b <= 8'h7E))) b = 8'h0D;
      do_byte(b, 100, act);
      check_byte(act);
    end
    mem_compare("rand_mem");

    // backspace at column 0, backspace at column 3, bell
    do_byte(8'h0D, 100, act);
    check_byte(act);
    do_byte(8'h08, 100, act);
    check("bs0_n", log_q.size(), 2);
    check_byte(act);
    for (int i = 0; i < 3; i++) begin
      do_byte(8'h62, 100, act);
      check_byte(act);
    end
    do_byte(8'h08, 100, act);
    check("bs3_n",  log_q.size(), 3);
    check("bs3_gm", log_q.size() > 0 ? log_q[0] : '0, ent(1, 32'(mrow * 80 + 2), 8'h20));
    check("bs3_col", cursor_col_o, 2);
    check_byte(act);
    do_byte(8'h07, 100, act);
    repeat (5) @(posedge clk);
    #1;
    check("bell_nobus", log_q.size(), 0);
    check("bell_busy", busy_o, 0);

    // reach 59,5 then LF forces a full scroll
    for (int i = 0; i < 60 && mrow < 59; i++) do_byte(8'h0A, 100, act);
    do_byte(8'h0D, 100, act);
    for (int i = 0; i < 5; i++) do_byte(8'h63, 100, act);
    check("pre_scroll_cur", {cursor_row_o, cursor_col_o}, {8'd59, 8'd5});
    @(negedge clk);
    fill_lo = 80; fill_hi = 159; fill_val = 8'h31; fill_req = 1'b1;
    @(negedge clk) fill_req = 1'b0;
    for (int i = 80; i < 160; i++) scr[i] = 8'h31;
    for (int i = 0; i < 4800; i++) pre[i] = scr[i];
    do_byte(8'h0A, 40000, act);
    check("scr_n", log_q.size(), 9522);
    rd = 0; bad = 0;
    for (int k = 0; k < 4720 && 2 * k + 1 < log_q.size(); k++) begin
      if (log_q[2*k][40] == 1'b0) rd++;
      if (log_q[2*k][40:8] !== {1'b0, 32'(k + 80)}) bad++;
      if (log_q[2*k+1] !== ent(1, 32'(k), pre[k + 80])) bad++;
    end
    check("scr_reads", rd, 4720);
    check("scr_order", bad, 0);
    bad = 0;
    for (int j = 0; j < 80 && 9440 + j < log_q.size(); j++)
      if (log_q[9440 + j] !== ent(1, 32'(4720 + j), 8'h20)) bad++;
    check("scr_clr_order", bad, 0);
    bad = 0;
    for (int i = 0; i < 80; i++) if (mem[i] !== 8'h31) bad++;
    check("scr_row0", bad, 0);
    bad = 0;
    for (int i = 4720; i < 4800; i++) if (mem[i] !== 8'h20) bad++;
    check("scr_lastrow", bad, 0);
    check("scr_cur", {cursor_row_o, cursor_col_o}, {8'd59, 8'd0});
    check_byte(act);
    mem_compare("scr_mem");
    check("proto_gap", proto_err, 0);
    check("data_hi", hi_err, 0);

    // form feed interrupted by reset during the 100th clear write
    log_q.delete();
    send_byte(8'h0C);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (log_q.size() >= 100) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("ff_reach100", ok, 1);
    check("ff_100th", log_q.size() >= 100 ? log_q[99] : '0, ent(1, 32'd99, 8'h20));
    check("ff_cs_before", bus_cs_o, 1);
    reset_i = 1'b1;
    #1;
    check("ff_cs_drop", bus_cs_o, 0);
    check("ff_rst_busy", busy_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    log_q.delete();
    reset_i = 1'b0;
    @(posedge clk); #1;
    wait_idle(100, ok);
    check("reinit_done", ok, 1);
    check_init("reinit");
    check("reinit_en_reg", reg_en, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
